// File: rtl/k051316_vt_pkg.sv
// Shared timing defaults and counter widths for the 051316 raster generator.
package k051316_vt_pkg;

    localparam int unsigned CNT_W   = 9;
    localparam int unsigned FRAME_W = 8;
    localparam int unsigned CNT_MAX = 1 << CNT_W;

    localparam int unsigned H_TOTAL_DEF      = 384;
    localparam int unsigned H_ACTIVE_DEF     = 256;
    localparam int unsigned H_SYNC_START_DEF = 288;
    localparam int unsigned H_SYNC_LEN_DEF   = 32;

    localparam int unsigned V_TOTAL_DEF      = 264;
    localparam int unsigned V_ACTIVE_DEF     = 224;
    localparam int unsigned V_SYNC_START_DEF = 240;
    localparam int unsigned V_SYNC_LEN_DEF   = 8;

endpackage

// File: rtl/k051316_vt_cnt.sv
// Wrapping beam counter with carry-out and registered active/sync window
// decodes taken from the value being loaded, so decodes always match cnt.
module k051316_vt_cnt
    import k051316_vt_pkg::*;
#(
    parameter int unsigned TOTAL      = H_TOTAL_DEF,
    parameter int unsigned ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned SYNC_START = H_SYNC_START_DEF,
    parameter int unsigned SYNC_LEN   = H_SYNC_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             carry_c,
    output logic             active,
    output logic             sync
);

    logic [CNT_W-1:0] nxt;
    logic [31:0]      nxt_w;

    assign carry_c = (cnt == CNT_W'(TOTAL - 1));
    assign nxt     = carry_c ? '0 : cnt + CNT_W'(1);
    assign nxt_w   = 32'(nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= CNT_W'(TOTAL - 1);
            active <= 1'b0;
            sync   <= 1'b0;
        end else if (en) begin
            cnt    <= nxt;
            active <= (nxt_w < ACTIVE);
            sync   <= (nxt_w >= SYNC_START) && (nxt_w < SYNC_START + SYNC_LEN);
        end
    end

endmodule

// File: rtl/k051316_vtgen.sv
// Raster timing generator for the 051316: M6 divider, H/V beam counters,
// frame counter and a vblank interrupt with CPU acknowledge.
module k051316_vtgen
    import k051316_vt_pkg::*;
#(
    parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
    parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned H_SYNC_START = H_SYNC_START_DEF,
    parameter int unsigned H_SYNC_LEN   = H_SYNC_LEN_DEF,
    parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
    parameter int unsigned V_SYNC_START = V_SYNC_START_DEF,
    parameter int unsigned V_SYNC_LEN   = V_SYNC_LEN_DEF
) (
    input  logic               M12,
    input  logic               nRES,
    output logic               M6,
    output logic               HSCN,
    output logic               VSCN,
    output logic               HRC,
    output logic               VRC,
    output logic [CNT_W-1:0]   H,
    output logic [CNT_W-1:0]   V,
    output logic [FRAME_W-1:0] FRAME,
    output logic               IRQ_n,
    input  logic               ACK_n
);

    if (H_TOTAL > CNT_MAX || H_ACTIVE > H_TOTAL ||
        H_SYNC_START + H_SYNC_LEN > H_TOTAL) begin : g_bad_h
        $error("k051316_vtgen: illegal horizontal timing parameters");
    end
    if (V_TOTAL > CNT_MAX || V_ACTIVE > V_TOTAL ||
        V_SYNC_START + V_SYNC_LEN > V_TOTAL) begin : g_bad_v
        $error("k051316_vtgen: illegal vertical timing parameters");
    end

    logic        advance;
    logic        h_carry;
    logic        v_carry;
    logic        v_en;
    logic        irq_set;
    logic [31:0] v_nxt;

    // Advance happens on the M12 edge where M6 falls.
    assign advance = M6;
    assign v_en    = advance & h_carry;
    assign v_nxt   = v_carry ? 32'd0 : 32'(V) + 32'd1;
    assign irq_set = v_en && (v_nxt == V_ACTIVE);

    always_ff @(posedge M12 or negedge nRES) begin
        if (!nRES) begin
            M6 <= 1'b0;
        end else begin
            M6 <= ~M6;
        end
    end

    k051316_vt_cnt #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_SYNC_START),
        .SYNC_LEN   (H_SYNC_LEN)
    ) u_h_cnt (
        .clk     (M12),
        .rst_n   (nRES),
        .en      (advance),
        .cnt     (H),
        .carry_c (h_carry),
        .active  (HSCN),
        .sync    (HRC)
    );

    k051316_vt_cnt #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_SYNC_START),
        .SYNC_LEN   (V_SYNC_LEN)
    ) u_v_cnt (
        .clk     (M12),
        .rst_n   (nRES),
        .en      (v_en),
        .cnt     (V),
        .carry_c (v_carry),
        .active  (VSCN),
        .sync    (VRC)
    );

    // Frame count steps on the advance into (0,0).
    always_ff @(posedge M12 or negedge nRES) begin
        if (!nRES) begin
            FRAME <= '0;
        end else if (v_en && v_carry) begin
            FRAME <= FRAME + FRAME_W'(1);
        end
    end

    // Set has priority over a simultaneous acknowledge.
    always_ff @(posedge M12 or negedge nRES) begin
        if (!nRES) begin
            IRQ_n <= 1'b1;
        end else if (irq_set) begin
            IRQ_n <= 1'b0;
        end else if (!ACK_n) begin
            IRQ_n <= 1'b1;
        end
    end

endmodule

// File: tb/tb_k051316_vtgen.sv
// Scoreboarded bench for k051316_vtgen using a shrunk raster so that many
// frames (and the FRAME wrap) fit in a short run.
module tb_k051316_vtgen;

    localparam int HT  = 10;
    localparam int HA  = 6;
    localparam int HSS = 7;
    localparam int HSL = 2;
    localparam int VT  = 8;
    localparam int VA  = 5;
    localparam int VSS = 6;
    localparam int VSL = 1;
    localparam int FRAME_CYC = 2 * HT * VT;

    localparam logic [31:0] RST_VEC = {1'b0, 4'b0000, 9'(HT - 1), 9'(VT - 1), 8'd0, 1'b1};

    logic       M12   = 1'b0;
    logic       nRES  = 1'b0;
    logic       ACK_n = 1'b1;
    logic       M6, HSCN, VSCN, HRC, VRC, IRQ_n;
    logic [8:0] H, V;
    logic [7:0] FRAME;

    k051316_vtgen #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
    ) dut (
        .M12(M12), .nRES(nRES), .M6(M6), .HSCN(HSCN), .VSCN(VSCN),
        .HRC(HRC), .VRC(VRC), .H(H), .V(V), .FRAME(FRAME),
        .IRQ_n(IRQ_n), .ACK_n(ACK_n)
    );

    always #5 M12 = ~M12;

    int n_checks = 0;
    int n_errors = 0;

    int m_h, m_v, m_frame;
    bit m_m6, m_irq;
    logic [31:0] sb[$];
    logic [31:0] exp_v, got_v;

    function automatic logic [31:0] obs();
        return {M6, HSCN, VSCN, HRC, VRC, H, V, FRAME, IRQ_n};
    endfunction

    function automatic logic [31:0] model_vec();
        return {m_m6, (m_h < HA), (m_v < VA),
                (m_h >= HSS && m_h < HSS + HSL), (m_v >= VSS && m_v < VSS + VSL),
                9'(m_h), 9'(m_v), 8'(m_frame), m_irq};
    endfunction

    task automatic model_reset();
        m_m6 = 1'b0; m_h = HT - 1; m_v = VT - 1; m_frame = 0; m_irq = 1'b1;
    endtask

    task automatic model_edge();
        bit wrap, set;
        set = 1'b0;
        if (!nRES) begin
            model_reset();
        end else begin
            if (m_m6) begin
                wrap = (m_h == HT - 1);
                m_h  = wrap ? 0 : m_h + 1;
                if (wrap) begin
                    m_v = (m_v == VT - 1) ? 0 : m_v + 1;
                    if (m_v == 0) m_frame = (m_frame + 1) % 256;
                    if (m_v == VA) set = 1'b1;
                end
            end
            if (set) m_irq = 1'b0;
            else if (!ACK_n) m_irq = 1'b1;
            m_m6 = !m_m6;
        end
    endtask

    task automatic tick();
        @(posedge M12);
        model_edge();
        sb.push_back(model_vec());
        #1;
    endtask

    task automatic test_reset();
        nRES = 1'b0; ACK_n = 1'b1;
        model_reset();
        repeat (4) begin
            tick();
            exp_v = sb.pop_front(); got_v = obs(); n_checks++;
            if (got_v !== exp_v) begin n_errors++; $display("FAIL reset_hold got=%h exp=%h", got_v, exp_v); end
        end
        n_checks++;
        if (obs() !== RST_VEC) begin n_errors++; $display("FAIL reset_values got=%h exp=%h", obs(), RST_VEC); end
        nRES = 1'b1;
        repeat (2) begin
            tick();
            exp_v = sb.pop_front(); got_v = obs(); n_checks++;
            if (got_v !== exp_v) begin n_errors++; $display("FAIL reset_release got=%h exp=%h", got_v, exp_v); end
        end
        n_checks++;
        if ({HSCN, VSCN, H, V, FRAME} !== {1'b1, 1'b1, 9'd0, 9'd0, 8'd1}) begin
            n_errors++;
            $display("FAIL first_advance got hscn=%b vscn=%b h=%0d v=%0d frame=%0d exp 1 1 0 0 1", HSCN, VSCN, H, V, FRAME);
        end
    endtask

    task automatic test_horizontal();
        int hs_hi, overlap, rise_h, fall_h;
        logic prev_hrc;
        hs_hi = 0; overlap = 0; rise_h = -1; fall_h = -1;
        prev_hrc = HRC;
        for (int i = 0; i < 4 * HT; i++) begin
            tick();
            exp_v = sb.pop_front(); got_v = obs(); n_checks++;
            if (got_v !== exp_v) begin n_errors++; $display("FAIL horiz_vec got=%h exp=%h", got_v, exp_v); end
            if (HSCN) hs_hi++;
            if (HSCN && HRC) overlap++;
            if (HRC && !prev_hrc && rise_h < 0) rise_h = int'(H);
            if (!HRC && prev_hrc && fall_h < 0) fall_h = int'(H);
            prev_hrc = HRC;
        end
        n_checks++;
        if (hs_hi != 4 * HA) begin n_errors++; $display("FAIL hscn_duty got=%0d exp=%0d", hs_hi, 4 * HA); end
        n_checks++;
        if (overlap != 0) begin n_errors++; $display("FAIL hscn_hrc_overlap got=%0d exp=0", overlap); end
        n_checks++;
        if (rise_h != HSS) begin n_errors++; $display("FAIL hrc_rise got=%0d exp=%0d", rise_h, HSS); end
        n_checks++;
        if (fall_h != HSS + HSL) begin n_errors++; $display("FAIL hrc_fall got=%0d exp=%0d", fall_h, HSS + HSL); end
    endtask

    task automatic test_vertical();
        int vs_hi, vrc_hi, frame_incs, vscn_fall_v, vrc_rise_v;
        bit saw_fwrap, saw_vwrap;
        logic [7:0] prev_frame;
        logic [8:0] prev_v;
        logic prev_vscn, prev_vrc;
        vs_hi = 0; vrc_hi = 0; frame_incs = 0; vscn_fall_v = -1; vrc_rise_v = -1;
        saw_fwrap = 1'b0; saw_vwrap = 1'b0;
        prev_frame = FRAME; prev_v = V; prev_vscn = VSCN; prev_vrc = VRC;
        for (int i = 0; i < FRAME_CYC * 257; i++) begin
            tick();
            exp_v = sb.pop_front(); got_v = obs(); n_checks++;
            if (got_v !== exp_v) begin n_errors++; $display("FAIL vert_vec got=%h exp=%h", got_v, exp_v); end
            if (i < FRAME_CYC) begin
                if (VSCN) vs_hi++;
                if (VRC) vrc_hi++;
            end
            if (FRAME != prev_frame) frame_incs++;
            if (prev_frame == 8'd255 && FRAME == 8'd0) saw_fwrap = 1'b1;
            if (prev_v == 9'(VT - 1) && V == 9'd0) saw_vwrap = 1'b1;
            if (!VSCN && prev_vscn && vscn_fall_v < 0) vscn_fall_v = int'(V);
            if (VRC && !prev_vrc && vrc_rise_v < 0) vrc_rise_v = int'(V);
            prev_frame = FRAME; prev_v = V; prev_vscn = VSCN; prev_vrc = VRC;
        end
        n_checks++;
        if (vs_hi != 2 * HT * VA) begin n_errors++; $display("FAIL vscn_duty got=%0d exp=%0d", vs_hi, 2 * HT * VA); end
        n_checks++;
        if (vrc_hi != 2 * HT * VSL) begin n_errors++; $display("FAIL vrc_duty got=%0d exp=%0d", vrc_hi, 2 * HT * VSL); end
        n_checks++;
        if (frame_incs != 257) begin n_errors++; $display("FAIL frame_incs got=%0d exp=257", frame_incs); end
        n_checks++;
        if (!saw_fwrap) begin n_errors++; $display("FAIL frame_wrap got=0 exp=1"); end
        n_checks++;
        if (!saw_vwrap) begin n_errors++; $display("FAIL v_wrap got=0 exp=1"); end
        n_checks++;
        if (vscn_fall_v != VA) begin n_errors++; $display("FAIL vscn_fall got=%0d exp=%0d", vscn_fall_v, VA); end
        n_checks++;
        if (vrc_rise_v != VSS) begin n_errors++; $display("FAIL vrc_rise got=%0d exp=%0d", vrc_rise_v, VSS); end
    endtask

    task automatic test_irq();
        bit found;
        ACK_n = 1'b0;
        tick();
        exp_v = sb.pop_front(); got_v = obs(); n_checks++;
        if (got_v !== exp_v) begin n_errors++; $display("FAIL irq_clear_vec got=%h exp=%h", got_v, exp_v); end
        ACK_n = 1'b1;
        n_checks++;
        if (IRQ_n !== 1'b1) begin n_errors++; $display("FAIL irq_initial_ack got=%b exp=1", IRQ_n); end

        found = 1'b0;
        for (int i = 0; i < FRAME_CYC + 4; i++) begin
            tick();
            exp_v = sb.pop_front(); got_v = obs(); n_checks++;
            if (got_v !== exp_v) begin n_errors++; $display("FAIL irq_wait_vec got=%h exp=%h", got_v, exp_v); end
            if (IRQ_n === 1'b0) begin found = 1'b1; break; end
        end
        n_checks++;
        if (!found || H !== 9'd0 || V !== 9'(VA)) begin
            n_errors++;
            $display("FAIL irq_set_point got found=%b h=%0d v=%0d exp found=1 h=0 v=%0d", found, H, V, VA);
        end

        repeat (30) begin
            tick();
            exp_v = sb.pop_front(); got_v = obs(); n_checks++;
            if (got_v !== exp_v) begin n_errors++; $display("FAIL irq_hold_vec got=%h exp=%h", got_v, exp_v); end
        end
        n_checks++;
        if (IRQ_n !== 1'b0) begin n_errors++; $display("FAIL irq_stays_low got=%b exp=0", IRQ_n); end

        ACK_n = 1'b0;
        tick();
        exp_v = sb.pop_front(); got_v = obs(); n_checks++;
        if (got_v !== exp_v) begin n_errors++; $display("FAIL irq_ack_vec got=%h exp=%h", got_v, exp_v); end
        ACK_n = 1'b1;
        n_checks++;
        if (IRQ_n !== 1'b1) begin n_errors++; $display("FAIL irq_ack_pulse got=%b exp=1", IRQ_n); end

        ACK_n = 1'b0;
        found = 1'b0;
        for (int i = 0; i < FRAME_CYC + 4; i++) begin
            tick();
            exp_v = sb.pop_front(); got_v = obs(); n_checks++;
            if (got_v !== exp_v) begin n_errors++; $display("FAIL irq_held_wait_vec got=%h exp=%h", got_v, exp_v); end
            if (M6 === 1'b1 && H === 9'(HT - 1) && V === 9'(VA - 1)) begin found = 1'b1; break; end
        end
        n_checks++;
        if (!found) begin n_errors++; $display("FAIL irq_held_timeout got=0 exp=1"); end
        tick();
        exp_v = sb.pop_front(); got_v = obs(); n_checks++;
        if (got_v !== exp_v) begin n_errors++; $display("FAIL irq_held_set_vec got=%h exp=%h", got_v, exp_v); end
        n_checks++;
        if (IRQ_n !== 1'b0) begin n_errors++; $display("FAIL irq_set_wins got=%b exp=0", IRQ_n); end
        tick();
        exp_v = sb.pop_front(); got_v = obs(); n_checks++;
        if (got_v !== exp_v) begin n_errors++; $display("FAIL irq_held_clr_vec got=%h exp=%h", got_v, exp_v); end
        n_checks++;
        if (IRQ_n !== 1'b1) begin n_errors++; $display("FAIL irq_held_clears got=%b exp=1", IRQ_n); end
        ACK_n = 1'b1;
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 1'b0;
        for (int i = 0; i < FRAME_CYC + 4; i++) begin
            tick();
            exp_v = sb.pop_front(); got_v = obs(); n_checks++;
            if (got_v !== exp_v) begin n_errors++; $display("FAIL midrst_wait_vec got=%h exp=%h", got_v, exp_v); end
            if (V === 9'd3 && H === 9'd4) begin found = 1'b1; break; end
        end
        n_checks++;
        if (!found) begin n_errors++; $display("FAIL midrst_timeout got=0 exp=1"); end
        #2;
        nRES = 1'b0;
        #1;
        model_reset();
        sb.push_back(model_vec());
        exp_v = sb.pop_front(); got_v = obs(); n_checks++;
        if (got_v !== exp_v) begin n_errors++; $display("FAIL midrst_async got=%h exp=%h", got_v, exp_v); end
        n_checks++;
        if (obs() !== RST_VEC) begin n_errors++; $display("FAIL midrst_values got=%h exp=%h", obs(), RST_VEC); end
        repeat (3) begin
            tick();
            exp_v = sb.pop_front(); got_v = obs(); n_checks++;
            if (got_v !== exp_v) begin n_errors++; $display("FAIL midrst_hold got=%h exp=%h", got_v, exp_v); end
        end
        nRES = 1'b1;
        repeat (2) begin
            tick();
            exp_v = sb.pop_front(); got_v = obs(); n_checks++;
            if (got_v !== exp_v) begin n_errors++; $display("FAIL midrst_release got=%h exp=%h", got_v, exp_v); end
        end
        n_checks++;
        if ({HSCN, VSCN, H, V, FRAME, IRQ_n} !== {1'b1, 1'b1, 9'd0, 9'd0, 8'd1, 1'b1}) begin
            n_errors++;
            $display("FAIL midrst_first_advance got h=%0d v=%0d frame=%0d irq_n=%b exp 0 0 1 1", H, V, FRAME, IRQ_n);
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_vertical();
        test_irq();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
